// File: rtl/da_fir_seq.sv
// da_fir_seq: bit-serial distributed-arithmetic FIR sequencer.
// The block keeps a TAPS-deep sample delay line and walks the sample bit-planes
// MSB-first. Each plane is presented to an external combinational coefficient
// LUT. The returned partial sums are shift-accumulated into one output.
module da_fir_seq #(
  parameter int TAPS  = 8,
  parameter int DW    = 8,
  parameter int LW    = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  output logic [TAPS-1:0]  lut_addr,
  input  logic [LW-1:0]    lut_data,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  input  logic             out_ready
);

  localparam int KW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  state_q, state_d;
  logic [TAPS-1:0][DW-1:0] tap_q, tap_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [KW-1:0]           k_q, k_d;
  logic [TAPS-1:0]         plane;

  // Bit k of every tap forms the current LUT address (tap 0 = newest).
  for (genvar i = 0; i < TAPS; i++) begin : g_plane
    assign plane[i] = tap_q[i][k_q];
  end

  assign lut_addr  = (state_q == CALC) ? plane : '0;
  // flush masks acceptance so that a sample offered alongside it is never lost silently.
  assign in_ready  = (state_q == IDLE) && !flush;
  assign out_valid = (state_q == DONE);
  assign out_data  = acc_q;

  // Next-state logic. flush overrides every state and clears all working data.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    acc_d   = acc_q;
    k_d     = k_q;
    if (flush) begin
      state_d = IDLE;
      tap_d   = '0;
      acc_d   = '0;
      k_d     = '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          tap_d   = {tap_q[TAPS-2:0], in_data};
          acc_d   = '0;
          k_d     = KW'(DW - 1);
          state_d = CALC;
        end
        CALC: begin
          // The accumulator wraps modulo 2^ACC_W. No overflow status is kept.
          acc_d = {acc_q[ACC_W-2:0], 1'b0} + ACC_W'(lut_data);
          if (k_q == '0) state_d = DONE;
          else           k_d     = k_q - KW'(1);
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tap_q   <= '0;
      acc_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: tb/tb_da_fir_seq.sv
// tb_da_fir_seq: randomized and directed checks of da_fir_seq.
// The LUT is popcount(addr), so every output equals the tap sum modulo 2^ACC_W.
// A second instance with ACC_W=10 shares the same inputs to exercise wrap-around.
module tb_da_fir_seq;
  localparam int TAPS = 8, DW = 8, LW = 16;

  logic             clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 1;
  logic [DW-1:0]    in_data = '0;
  logic             in_ready, out_valid, in_ready_w, out_valid_w;
  logic [TAPS-1:0]  lut_addr, lut_addr_w;
  logic [LW-1:0]    lut_data, lut_data_w;
  logic [23:0]      out_data;
  logic [9:0]       out_data_w;

  int n_cmp = 0, n_bad = 0;
  int taps [TAPS];

  always #5 clk = ~clk;

  assign lut_data   = LW'($countones(lut_addr));
  assign lut_data_w = LW'($countones(lut_addr_w));

  da_fir_seq #(.TAPS(TAPS), .DW(DW), .LW(LW), .ACC_W(24)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .lut_addr(lut_addr), .lut_data(lut_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready));

  da_fir_seq #(.TAPS(TAPS), .DW(DW), .LW(LW), .ACC_W(10)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_w), .lut_addr(lut_addr_w), .lut_data(lut_data_w),
    .out_valid(out_valid_w), .out_data(out_data_w), .out_ready(out_ready));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < TAPS; i++) taps[i] = 0;
  endfunction

  function automatic void model_push(input int d);
    for (int i = TAPS - 1; i > 0; i--) taps[i] = taps[i-1];
    taps[0] = d;
  endfunction

  function automatic int model_sum();
    int s = 0;
    for (int i = 0; i < TAPS; i++) s += taps[i];
    return s;
  endfunction

  function automatic logic [TAPS-1:0] model_plane(input int k);
    logic [TAPS-1:0] a;
    for (int i = 0; i < TAPS; i++) a[i] = 1'((taps[i] >> k) & 1);
    return a;
  endfunction

  // Offer one sample from IDLE and complete the handshake.
  task automatic do_hs(input int d);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; in_data = DW'(d);
    @(posedge clk);
    model_push(d);
    #1 in_valid = 0;
  endtask

  // Follow the computation: plane addresses, latency, result, then an optional hold before acceptance.
  task automatic collect(input int hold);
    bit seen = 0;
    int exp = model_sum();
    out_ready = (hold == 0);
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (!out_valid) begin
        if (c <= DW) chk("lut_addr", lut_addr, model_plane(DW - c));
      end else begin
        seen = 1;
        chk("latency", c, DW + 1);
        chk("out_data", out_data, exp & 24'hFFFFFF);
        chk("out_data_w", out_data_w, exp & 10'h3FF);
        chk("out_valid_w", out_valid_w, 1);
        chk("lut_addr_done", lut_addr, 0);
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, exp & 24'hFFFFFF);
        end
        out_ready = 1;
        @(posedge clk);
      end
    end
    if (!seen) chk("timeout_out_valid", 0, 1);
  endtask

  initial begin
    int exp;
    model_clear();
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_lut_addr", lut_addr, 0);
    #20 rst_n = 1;

    // Reset, then idle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_lut_addr", lut_addr, 0);
    end

    // Impulse: 255 followed by zeros
    for (int i = 0; i < 9; i++) begin
      do_hs(i == 0 ? 255 : 0);
      collect(0);
    end

    // Step: ten samples of 255 (the 2040 outputs wrap to 1016 at 10 bits)
    for (int i = 0; i < 10; i++) begin
      do_hs(255);
      collect(0);
    end

    // Back-pressure with a sample offered during DONE
    do_hs(3);
    exp = model_sum();
    out_ready = 0;
    begin
      bit seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        seen = out_valid;
      end
      if (!seen) chk("timeout_bp", 0, 1);
    end
    in_valid = 1; in_data = 7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, exp);
    end
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_after_ack", in_ready, 1);
    @(posedge clk);
    model_push(7);
    #1 in_valid = 0;
    collect(0);

    // Randomized samples with random acceptance delay
    for (int i = 0; i < 24; i++) begin
      do_hs($urandom_range(0, 255));
      collect($urandom_range(0, 3));
    end

    // Flush mid-CALC
    for (int i = 0; i < 3; i++) begin
      do_hs(100);
      collect(0);
    end
    do_hs(100);
    repeat (3) @(negedge clk);
    flush = 1;
    @(posedge clk);
    model_clear();
    #1 flush = 0;
    begin
      int vcnt = 0;
      for (int i = 0; i < 14; i++) begin
        @(negedge clk);
        if (out_valid) vcnt++;
      end
      chk("flush_no_valid", vcnt, 0);
    end
    // flush in IDLE blocks a simultaneous sample
    @(negedge clk);
    flush = 1; in_valid = 1; in_data = 77;
    #1 chk("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1 begin flush = 0; in_valid = 0; end
    @(negedge clk);
    chk("flush_sample_dropped", in_ready, 1);
    do_hs(5);
    collect(0);

    // Async reset mid-CALC
    do_hs(9);
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_lut_addr", lut_addr, 0);
    chk("arst_out_data_w", out_data_w, 0);
    model_clear();
    @(negedge clk);
    #1 rst_n = 1;
    begin
      int vcnt = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (out_valid) vcnt++;
      end
      chk("arst_no_valid", vcnt, 0);
    end
    do_hs(1);
    collect(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
